// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux lane scheduler.
// Lane select type, lane count, FSM states and destination modes.
package demux_sched_pkg;

  typedef logic [1:0] lane_sel_t;

  localparam int LANES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

endpackage

// File: rtl/rr_lane_picker.sv
// Round-robin lane picker: first set bit of mask_i scanning from start_i.
// Ports: mask_i/start_i in; pick_o (start_i if none ready), any_o out.
module rr_lane_picker
  import demux_sched_pkg::*;
(
  input  logic [3:0] mask_i,
  input  lane_sel_t  start_i,
  output lane_sel_t  pick_o,
  output logic       any_o
);

  // Scan downward so the lowest offset from start_i wins.
  always_comb begin
    pick_o = start_i;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_i[2'(start_i + 2'(i))]) begin
        pick_o = 2'(start_i + 2'(i));
      end
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/demux_lane_scheduler.sv
// Sequencer for a 1-to-4 demux: holds one word, steers it to a lane.
// Ports: IN_* upstream handshake, OUT_* per-lane, SELECT/DEMUX_DATA/BUSY.
module demux_lane_scheduler
  import demux_sched_pkg::*;
#(
  parameter int BITS    = 4,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [BITS-1:0] IN_DATA,
  input  logic [1:0]      IN_DEST,
  input  logic            MODE,
  input  logic [3:0]      OUT_READY,
  output logic [3:0]      OUT_VALID,
  output logic [1:0]      SELECT,
  output logic [BITS-1:0] DEMUX_DATA,
  output logic            BUSY
);

  sched_state_t    state_q, state_d;
  lane_sel_t       ptr_q, ptr_d;
  lane_sel_t       sel_q, sel_d;
  logic [BITS-1:0] data_q, data_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic            mode_q, mode_d;
  logic [3:0]      ov_q, ov_d;

  logic      hold;
  logic      lane_rdy;
  logic      xfer;
  logic      cap;
  logic      stall_max;
  logic      resteer;
  lane_sel_t ptr_nx;
  lane_sel_t sel_inc;
  lane_sel_t cap_pick;
  lane_sel_t cap_lane;
  logic      cap_any;
  logic [3:0] other_mask;
  lane_sel_t rs_pick;
  logic      rs_any;

  assign hold     = (state_q == HOLD);
  assign lane_rdy = OUT_READY[sel_q];
  assign xfer     = hold & lane_rdy;

  assign IN_READY = ~RESET & (hold ? lane_rdy : 1'b1);
  assign cap      = IN_VALID & IN_READY;

  // A same-cycle transfer advances the pointer before the new scan.
  assign sel_inc = sel_q + 2'd1;
  assign ptr_nx  = xfer ? sel_inc : ptr_q;

  rr_lane_picker u_cap_pick (
    .mask_i  (OUT_READY),
    .start_i (ptr_nx),
    .pick_o  (cap_pick),
    .any_o   (cap_any)
  );

  assign cap_lane = cap_any ? cap_pick : ptr_nx;

  // Re-steer only considers lanes other than the stalled one.
  assign other_mask = OUT_READY & ~(4'b0001 << sel_q);

  rr_lane_picker u_rs_pick (
    .mask_i  (other_mask),
    .start_i (sel_inc),
    .pick_o  (rs_pick),
    .any_o   (rs_any)
  );

  assign stall_max = (stall_q == CNT_W'(TIMEOUT));
  assign resteer   = hold & ~xfer & (mode_q == MODE_RR)
                   & stall_max & rs_any;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    stall_d = stall_q;
    mode_d  = mode_q;
    ptr_d   = ptr_nx;
    if (cap) begin
      state_d = HOLD;
      data_d  = IN_DATA;
      mode_d  = MODE;
      sel_d   = (MODE == MODE_ADDR) ? IN_DEST : cap_lane;
      stall_d = '0;
    end else if (xfer) begin
      state_d = IDLE;
      stall_d = '0;
    end else if (resteer) begin
      sel_d   = rs_pick;
      stall_d = '0;
    end else if (hold && !stall_max) begin
      stall_d = stall_q + 1'b1;
    end
    ov_d = (state_d == HOLD) ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      stall_q <= '0;
      mode_q  <= MODE_RR;
      ov_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      mode_q  <= mode_d;
      ov_q    <= ov_d;
    end
  end

  assign OUT_VALID  = ov_q;
  assign SELECT     = sel_q;
  assign DEMUX_DATA = data_q;
  assign BUSY       = hold;

endmodule

// File: doc/demux_lane_scheduler.md
Name: demux_lane_scheduler

Overview:
- Sequencing controller for the 1-to-4 N-bit demux in the datapath.
- Accepts one N-bit word at a time through a valid/ready input port and holds it in a register.
- Picks a destination lane and drives the demux SELECT and data inputs until that lane accepts the word.
- Two destination modes: round-robin (skips lanes that are not ready, re-steers stalled words after a timeout) and addressed.

Parameters:
- BITS, 4, data word width; matches the demux BITS.
- TIMEOUT, 8, HOLD cycles without a handshake before a round-robin word is re-steered; must be ≥1.
- CNT_W, 4, stall counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  upstream word valid.
- IN_READY  out  1  scheduler can accept a word this cycle.
- IN_DATA  in  BITS  upstream word.
- IN_DEST  in  2  destination lane, used only when MODE=1.
- MODE  in  1  0 = round-robin, 1 = addressed; sampled only at capture.
- OUT_READY  in  4  per-lane downstream ready.
- OUT_VALID  out  4  one-hot lane valid; all zero when idle.
- SELECT  out  2  drives demux SELECT.
- DEMUX_DATA  out  BITS  drives demux IN_DATA; held word.
- BUSY  out  1  high in HOLD.

Behaviour:
- Single clock domain. One asynchronous, active-high reset.
- Reset values: state=IDLE, PTR=0, SELECT=0, DEMUX_DATA=0, OUT_VALID=0, BUSY=0, stall count=0, held mode=0. IN_READY=0 while RESET is high.
- Reset mid-HOLD discards the held word, with no output handshake.
- Outputs SELECT, DEMUX_DATA and OUT_VALID are registered. IN_READY is combinational.
- States:
  - IDLE: IN_READY=1.
  - HOLD: IN_READY=OUT_READY[SELECT], so back-to-back words run at 1 word per cycle.
- Capture (IN_VALID & IN_READY): register IN_DATA into DEMUX_DATA, compute the destination, go to or stay in HOLD, clear the stall count, and latch MODE.
- Destination rules:
  - MODE=1: IN_DEST.
  - MODE=0: the first lane with OUT_READY=1, scanning PTR, PTR+1, … mod 4. If no lane is ready, use PTR.
- Output handshake: OUT_VALID[SELECT]=1 in HOLD; a transfer happens when OUT_READY[SELECT]=1.
  - On transfer, PTR ← SELECT+1 (mod 4, wraps 3→0).
  - Transfer without a same-cycle capture → IDLE next cycle.
- Simultaneous transfer and capture:
  - The new word's round-robin scan starts from the post-update PTR (SELECT+1).
  - The scan mask is OUT_READY of the same cycle.
  - State stays HOLD.
- SELECT and DEMUX_DATA stay stable during HOLD, except on a re-steer.
- Stall and re-steer:
  - Stall count increments each HOLD cycle with no transfer, saturating at TIMEOUT.
  - Re-steer applies only if the held mode=0. When the count equals TIMEOUT and some other lane is ready, SELECT ← first ready lane scanning from SELECT+1, and the count clears. OUT_VALID moves with SELECT on the same edge.
  - With no other lane ready, hold and keep waiting.
  - In addressed mode there is never a re-steer.
- PTR is unchanged on re-steer and captures; it updates only on transfers.
- IN_DATA, IN_DEST and MODE are ignored when there is no capture.

Decomposition:
- Package demux_sched_pkg:
  - typedef lane_sel_t = logic[1:0].
  - LANES=4.
  - enum sched_state_t {IDLE, HOLD}.
  - MODE_RR=0, MODE_ADDR=1.
- One combinational sub-module, rr_lane_picker:
  - Inputs: 4-bit ready mask, 2-bit start pointer.
  - Outputs: lane_sel_t pick, any_ready.
  - Used for both capture selection and re-steer.

Test Plan:
1. Reset and idle: assert RESET mid-HOLD (SELECT=2, OUT_VALID=0100) → same cycle OUT_VALID=0000, SELECT=0, BUSY=0. After release, IN_READY=1 and PTR=0.
2. Round-robin, all ready: OUT_READY=1111, MODE=0, four back-to-back words A,B,C,D → lanes 0,1,2,3 on consecutive cycles, 1 word per cycle. A fifth word goes to lane 0 (wrap).
3. Round-robin skip: PTR=1, OUT_READY=1001, word 0x5 → SELECT=3, OUT_VALID=1000. On transfer PTR=0.
4. Addressed stall: MODE=1, IN_DEST=2, OUT_READY=0000 for 20 cycles → SELECT stays 2, IN_READY=0, no re-steer. Raising OUT_READY[2] transfers the word and returns to IDLE.
5. Re-steer: MODE=0, TIMEOUT=8, lane 0 is picked (no lane ready at capture). OUT_READY[0]=0 throughout; OUT_READY[3] rises at cycle 3 → SELECT changes 0→3 after the 8th stall cycle; transfer on lane 3 the next cycle.
6. Simultaneous events: in HOLD on lane 1, OUT_READY=1111 and IN_VALID=1 with word 0x9 → 0x9 captured the same cycle and routed to lane 2, BUSY stays 1.
